// File: rtl/ahb_error_subordinate.sv
// AHB-Lite default subordinate for decoder holes: ERROR or read-as-zero OKAY after WAIT_STATES waits.
// Define AHB_ERR_CAPTURE_EN to build the ERR_COUNT/ERR_ADDR/ERR_WRITE capture registers.
module ahb_error_subordinate #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_STATES = 0,
    parameter int MODE = 0,
    parameter logic [DATA_WIDTH-1:0] RDATA_VALUE = '0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADYin,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HRESP,
    output logic                  HREADYout,
    input  logic                  ERR_CLR,
    output logic [CNT_WIDTH-1:0]  ERR_COUNT,
    output logic [ADDR_WIDTH-1:0] ERR_ADDR,
    output logic                  ERR_WRITE
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP1,
        ST_RESP2
    } state_t;

    localparam logic [3:0] WAIT_LOAD  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam state_t     RESP_STATE = (MODE == 0) ? ST_RESP1 : ST_RESP2;

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;
    logic       pend_write, pend_write_nxt;
    logic       accept;
    logic       start;
    logic       unused_inputs;

    assign accept = HSEL & HREADYin & HTRANS[1];
    assign start  = accept && (state == ST_IDLE || state == ST_RESP2);

    // Only IDLE and RESP2 can take a new address phase; WAIT/RESP1 always run to completion.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        pend_write_nxt = pend_write;
        case (state)
            ST_IDLE, ST_RESP2: begin
                if (start) begin
                    pend_write_nxt = HWRITE;
                    wait_cnt_nxt   = WAIT_LOAD;
                    state_nxt      = (WAIT_STATES > 0) ? ST_WAIT : RESP_STATE;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP_STATE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ST_RESP1: state_nxt = ST_RESP2;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            pend_write <= 1'b0;
            HREADYout  <= 1'b1;
            HRESP      <= 1'b0;
            HRDATA     <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_cnt_nxt;
            pend_write <= pend_write_nxt;
            HREADYout  <= !(state_nxt == ST_WAIT || state_nxt == ST_RESP1);
            HRESP      <= (state_nxt == ST_RESP1) || (state_nxt == ST_RESP2 && MODE == 0);
            HRDATA     <= (state_nxt == ST_RESP2 && MODE != 0 && !pend_write_nxt) ? RDATA_VALUE : '0;
        end
    end

`ifdef AHB_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_nxt;
    logic [CNT_WIDTH-1:0]  err_count;
    logic [ADDR_WIDTH-1:0] err_addr;
    logic                  err_write;
    logic                  err_entry;

    assign pend_addr_nxt = start ? HADDR : pend_addr;
    // RESP1 never repeats, so being headed into it marks exactly one error per transfer.
    assign err_entry     = (state_nxt == ST_RESP1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_addr <= '0;
            err_count <= '0;
            err_addr  <= '0;
            err_write <= 1'b0;
        end else begin
            pend_addr <= pend_addr_nxt;
            if (ERR_CLR) begin
                err_count <= err_entry ? CNT_WIDTH'(1) : '0;
                err_addr  <= err_entry ? pend_addr_nxt : '0;
                err_write <= err_entry ? pend_write_nxt : 1'b0;
            end else if (err_entry) begin
                if (err_count != '1) begin
                    err_count <= err_count + CNT_WIDTH'(1);
                end
                err_addr  <= pend_addr_nxt;
                err_write <= pend_write_nxt;
            end
        end
    end

    assign ERR_COUNT     = err_count;
    assign ERR_ADDR      = err_addr;
    assign ERR_WRITE     = err_write;
    assign unused_inputs = ^{HTRANS[0], HSIZE, HBURST, HPROT, HWDATA};
`else
    assign ERR_COUNT     = '0;
    assign ERR_ADDR      = '0;
    assign ERR_WRITE     = 1'b0;
    assign unused_inputs = ^{HTRANS[0], HSIZE, HBURST, HPROT, HWDATA, HADDR, ERR_CLR};
`endif

endmodule

// File: tb/tb_ahb_error_subordinate.sv
// Bench for ahb_error_subordinate: four instances covering ERROR/OKAY modes, wait states and counter saturation.
module tb_ahb_error_subordinate;

`ifdef AHB_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef struct {
        int          dut;
        logic        rdy;
        logic        resp;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          dut;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] addr;
        logic        hold;
        int          waits;
        logic        err;
        logic [31:0] rdata;
        int          cnt;
        logic [31:0] eaddr;
        logic        ewrite;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [3:0]  hsel;
    logic [3:0]  err_clr;
    logic        hold;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic [3:0]  hready_in;
    logic [3:0]  hready_out;
    logic [3:0]  hresp;
    logic [31:0] hrdata [4];
    logic [15:0] err_count [4];
    logic [1:0]  cnt3;
    logic [31:0] err_addr [4];
    logic [3:0]  err_write;

    exp_t sb[$];
    vec_t vecs[15];
    int   checks = 0;
    int   passes = 0;

    always #5 hclk = ~hclk;

    assign hready_in    = hready_out & ~{4{hold}};
    assign err_count[3] = {14'd0, cnt3};

    ahb_error_subordinate #(.WAIT_STATES(0), .MODE(0)) u_m0_ws0 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADYin(hready_in[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0]), .HREADYout(hready_out[0]),
        .ERR_CLR(err_clr[0]), .ERR_COUNT(err_count[0]), .ERR_ADDR(err_addr[0]), .ERR_WRITE(err_write[0]));

    ahb_error_subordinate #(.WAIT_STATES(3), .MODE(0)) u_m0_ws3 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADYin(hready_in[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1]), .HREADYout(hready_out[1]),
        .ERR_CLR(err_clr[1]), .ERR_COUNT(err_count[1]), .ERR_ADDR(err_addr[1]), .ERR_WRITE(err_write[1]));

    ahb_error_subordinate #(.WAIT_STATES(2), .MODE(1), .RDATA_VALUE(32'hDEAD_BEEF)) u_m1_ws2 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADYin(hready_in[2]), .HRDATA(hrdata[2]), .HRESP(hresp[2]), .HREADYout(hready_out[2]),
        .ERR_CLR(err_clr[2]), .ERR_COUNT(err_count[2]), .ERR_ADDR(err_addr[2]), .ERR_WRITE(err_write[2]));

    ahb_error_subordinate #(.WAIT_STATES(1), .MODE(0), .CNT_WIDTH(2)) u_m0_cnt2 (
        .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[3]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
        .HREADYin(hready_in[3]), .HRDATA(hrdata[3]), .HRESP(hresp[3]), .HREADYout(hready_out[3]),
        .ERR_CLR(err_clr[3]), .ERR_COUNT(cnt3), .ERR_ADDR(err_addr[3]), .ERR_WRITE(err_write[3]));

    function automatic vec_t mkVec(int d, logic [1:0] t, logic w, logic [31:0] a, logic h,
                                   int ws, logic e, logic [31:0] rd, int c, logic [31:0] ea, logic ew);
        vec_t v;
        v.dut = d; v.trans = t; v.write = w; v.addr = a; v.hold = h;
        v.waits = ws; v.err = e; v.rdata = rd; v.cnt = c; v.eaddr = ea; v.ewrite = ew;
        return v;
    endfunction

    function automatic exp_t mkExp(int d, logic r, logic s, logic c, logic [31:0] x);
        exp_t e;
        e.dut = d; e.rdy = r; e.resp = s; e.chk_data = c; e.data = x;
        return e;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Pops the next expected bus-output record and compares it with the DUT it names.
    task automatic checkOutput(input string tag);
        exp_t e;
        e = sb.pop_front();
        checkValue($sformatf("%s dut%0d HREADYout", tag, e.dut), {31'd0, hready_out[e.dut]}, {31'd0, e.rdy});
        checkValue($sformatf("%s dut%0d HRESP", tag, e.dut), {31'd0, hresp[e.dut]}, {31'd0, e.resp});
        if (e.chk_data) begin
            checkValue($sformatf("%s dut%0d HRDATA", tag, e.dut), hrdata[e.dut], e.data);
        end
    endtask

    task automatic checkCapture(input string tag, input int d, input int cnt, input logic [31:0] ea, input logic ew);
        checkValue($sformatf("%s dut%0d ERR_COUNT", tag, d), {16'd0, err_count[d]}, CAP ? 32'(cnt) : 32'd0);
        checkValue($sformatf("%s dut%0d ERR_ADDR", tag, d), err_addr[d], CAP ? ea : 32'd0);
        checkValue($sformatf("%s dut%0d ERR_WRITE", tag, d), {31'd0, err_write[d]}, {31'd0, CAP & ew});
    endtask

    task automatic idleBus();
        hsel   = '0;
        htrans = T_IDLE;
        hold   = 1'b0;
        haddr  = $urandom;
        hwrite = 1'($urandom_range(0, 1));
    endtask

    // Drives one address phase and queues the data-phase cycles it should produce, plus the return to IDLE.
    task automatic applyStimulus(input vec_t v);
        @(negedge hclk);
        haddr       = v.addr;
        htrans      = v.trans;
        hwrite      = v.write;
        hold        = v.hold;
        hsel[v.dut] = 1'b1;
        hsize       = 3'($urandom_range(0, 7));
        hburst      = 3'($urandom_range(0, 7));
        hprot       = 4'($urandom_range(0, 15));
        hwdata      = $urandom;
        for (int w = 0; w < v.waits; w++) sb.push_back(mkExp(v.dut, 1'b0, 1'b0, 1'b0, 32'd0));
        if (v.err) begin
            sb.push_back(mkExp(v.dut, 1'b0, 1'b1, 1'b0, 32'd0));
            sb.push_back(mkExp(v.dut, 1'b1, 1'b1, 1'b1, 32'd0));
        end else begin
            sb.push_back(mkExp(v.dut, 1'b1, 1'b0, 1'b1, v.rdata));
        end
        sb.push_back(mkExp(v.dut, 1'b1, 1'b0, 1'b1, 32'd0));
        @(posedge hclk);
        #1;
        idleBus();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        hresetn = 1'b0;
        err_clr = '0;
        hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hwdata = 32'd0;
        idleBus();

        vecs[0]  = mkVec(0, T_NONSEQ, 1'b1, 32'h0000_1000, 1'b0, 0, 1'b1, 32'd0, 1, 32'h0000_1000, 1'b1);
        vecs[1]  = mkVec(0, T_NONSEQ, 1'b0, 32'h0000_1F00, 1'b1, 0, 1'b0, 32'd0, 1, 32'h0000_1000, 1'b1);
        vecs[2]  = mkVec(1, T_NONSEQ, 1'b0, 32'h0000_2004, 1'b0, 3, 1'b1, 32'd0, 1, 32'h0000_2004, 1'b0);
        vecs[3]  = mkVec(1, T_IDLE,   1'b0, 32'h0000_2008, 1'b0, 0, 1'b0, 32'd0, 1, 32'h0000_2004, 1'b0);
        vecs[4]  = mkVec(1, T_BUSY,   1'b1, 32'h0000_200C, 1'b0, 0, 1'b0, 32'd0, 1, 32'h0000_2004, 1'b0);
        vecs[5]  = mkVec(1, T_SEQ,    1'b1, 32'h0000_2010, 1'b0, 3, 1'b1, 32'd0, 2, 32'h0000_2010, 1'b1);
        vecs[6]  = mkVec(2, T_NONSEQ, 1'b0, 32'h0000_3000, 1'b0, 2, 1'b0, 32'hDEAD_BEEF, 0, 32'd0, 1'b0);
        vecs[7]  = mkVec(2, T_NONSEQ, 1'b1, 32'h0000_3004, 1'b0, 2, 1'b0, 32'd0, 0, 32'd0, 1'b0);
        vecs[8]  = mkVec(2, T_BUSY,   1'b0, 32'h0000_3008, 1'b0, 0, 1'b0, 32'd0, 0, 32'd0, 1'b0);
        vecs[9]  = mkVec(0, T_NONSEQ, 1'b0, 32'hFFFF_FFFC, 1'b0, 0, 1'b1, 32'd0, 2, 32'hFFFF_FFFC, 1'b0);
        for (int i = 0; i < 5; i++) begin
            vecs[10 + i] = mkVec(3, T_NONSEQ, 1'(i % 2), 32'h10 + 32'(4 * i), 1'b0, 1, 1'b1, 32'd0,
                                 (i + 1 > 3) ? 3 : i + 1, 32'h10 + 32'(4 * i), 1'(i % 2));
        end

        repeat (3) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);
        for (int d = 0; d < 4; d++) begin
            checkValue($sformatf("reset dut%0d HREADYout", d), {31'd0, hready_out[d]}, 32'd1);
            checkValue($sformatf("reset dut%0d HRESP", d), {31'd0, hresp[d]}, 32'd0);
            checkValue($sformatf("reset dut%0d HRDATA", d), hrdata[d], 32'd0);
            checkValue($sformatf("reset dut%0d ERR_COUNT", d), {16'd0, err_count[d]}, 32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            while (sb.size() > 0) begin
                @(negedge hclk);
                checkOutput($sformatf("vec%0d", i));
            end
            checkCapture($sformatf("vec%0d", i), vecs[i].dut, vecs[i].cnt, vecs[i].eaddr, vecs[i].ewrite);
        end

        // Back-to-back errors on dut0, with ERR_CLR landing on the first RESP1 entry.
        @(negedge hclk);
        hsel[0] = 1'b1; htrans = T_NONSEQ; hwrite = 1'b1; haddr = 32'h0000_4000; err_clr[0] = 1'b1;
        sb.push_back(mkExp(0, 1'b0, 1'b1, 1'b0, 32'd0));
        sb.push_back(mkExp(0, 1'b1, 1'b1, 1'b1, 32'd0));
        sb.push_back(mkExp(0, 1'b0, 1'b1, 1'b0, 32'd0));
        sb.push_back(mkExp(0, 1'b1, 1'b1, 1'b1, 32'd0));
        sb.push_back(mkExp(0, 1'b1, 1'b0, 1'b1, 32'd0));
        @(posedge hclk);
        #1;
        idleBus();
        err_clr = '0;
        @(negedge hclk);
        checkOutput("b2b first resp1");
        checkCapture("b2b clr", 0, 1, 32'h0000_4000, 1'b1);
        @(negedge hclk);
        checkOutput("b2b first resp2");
        hsel[0] = 1'b1; htrans = T_NONSEQ; hwrite = 1'b0; haddr = 32'h0000_4004;
        @(posedge hclk);
        #1;
        idleBus();
        @(negedge hclk);
        checkOutput("b2b second resp1");
        checkCapture("b2b second", 0, 2, 32'h0000_4004, 1'b0);
        @(negedge hclk);
        checkOutput("b2b second resp2");
        @(negedge hclk);
        checkOutput("b2b idle");

        // Reset pulse in the middle of dut1's wait states.
        @(negedge hclk);
        hsel[1] = 1'b1; htrans = T_NONSEQ; hwrite = 1'b0; haddr = 32'h0000_5000;
        @(posedge hclk);
        #1;
        idleBus();
        @(negedge hclk);
        checkValue("rst wait1 HREADYout", {31'd0, hready_out[1]}, 32'd0);
        checkValue("rst wait1 HRESP", {31'd0, hresp[1]}, 32'd0);
        @(posedge hclk);
        #1;
        hresetn = 1'b0;
        #1;
        checkValue("rst async HREADYout", {31'd0, hready_out[1]}, 32'd1);
        checkValue("rst async HRESP", {31'd0, hresp[1]}, 32'd0);
        checkValue("rst async ERR_COUNT", {16'd0, err_count[1]}, 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        repeat (5) @(negedge hclk);
        checkValue("rst after HREADYout", {31'd0, hready_out[1]}, 32'd1);
        checkValue("rst after HRESP", {31'd0, hresp[1]}, 32'd0);
        checkValue("rst after ERR_COUNT", {16'd0, err_count[1]}, 32'd0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
